// File: rtl/mem_access_unit.sv
// MEM-stage access unit: maps byte/half/word loads and stores onto a word-only data memory.
// Sub-word stores become a stalled read phase followed by a MERGE write of the patched word.
module mem_access_unit #(
  parameter int ADDR_MSB = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  input  logic [31:0] reqPc,
  output logic        stall,
  output logic        resultValid,
  output logic [31:0] resultData,
  output logic        misaligned,
  output logic [31:0] dmProgramCounter,
  output logic [31:0] dmAddress,
  output logic        dmWriteEnabled,
  output logic [31:0] dmWriteInput,
  input  logic [31:0] dmReadResult
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] merge_word_reg, merge_addr_reg, merge_pc_reg;
  logic [31:0] result_data_reg;
  logic        result_valid_reg, misaligned_reg;

  logic        size_byte, size_half, size_word, aligned, in_idle;
  logic        load_ok, word_store, sub_store, fault;
  logic [3:0]  lane_hit;
  logic [31:0] merged_word, load_value;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  if (ADDR_MSB < 2) begin : g_addr_check
    $error("ADDR_MSB must leave room for the byte offset");
  end

  assign size_byte  = (reqSize == 2'b00);
  assign size_half  = (reqSize == 2'b01);
  assign size_word  = reqSize[1];
  assign aligned    = size_byte | (size_half & ~reqAddress[0]) |
                      (size_word & (reqAddress[1:0] == 2'b00));
  assign in_idle    = (state_reg == IDLE);

  assign load_ok    = reqValid & ~reqWrite & aligned;
  assign word_store = reqValid & reqWrite & aligned & size_word;
  assign sub_store  = reqValid & reqWrite & aligned & ~size_word;
  assign fault      = reqValid & ~aligned;

  // Patch the target lane(s) of the current memory word with right-aligned store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_hit[gi] = size_byte ? (reqAddress[1:0] == 2'(gi))
                                    : (reqAddress[1] == 1'(gi / 2));
    assign merged_word[8*gi +: 8] =
      !lane_hit[gi] ? dmReadResult[8*gi +: 8] :
      size_byte     ? reqData[7:0] : reqData[8*(gi % 2) +: 8];
  end

  always_comb begin
    byte_val = dmReadResult[7:0];
    case (reqAddress[1:0])
      2'd1:    byte_val = dmReadResult[15:8];
      2'd2:    byte_val = dmReadResult[23:16];
      2'd3:    byte_val = dmReadResult[31:24];
      default: byte_val = dmReadResult[7:0];
    endcase
    half_val = reqAddress[1] ? dmReadResult[31:16] : dmReadResult[15:0];
    if (size_byte)
      load_value = {{24{~reqUnsigned & byte_val[7]}}, byte_val};
    else if (size_half)
      load_value = {{16{~reqUnsigned & half_val[15]}}, half_val};
    else
      load_value = dmReadResult;
  end

  always_comb begin
    state_next       = state_reg;
    stall            = 1'b0;
    dmWriteEnabled   = 1'b0;
    dmAddress        = reqAddress;
    dmProgramCounter = reqPc;
    dmWriteInput     = reqData;
    case (state_reg)
      IDLE: begin
        if (word_store) begin
          dmWriteEnabled = 1'b1;
        end else if (sub_store) begin
          stall      = 1'b1;
          state_next = MERGE;
        end
      end
      MERGE: begin
        dmAddress        = merge_addr_reg;
        dmProgramCounter = merge_pc_reg;
        dmWriteInput     = merge_word_reg;
        dmWriteEnabled   = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset abandons any pending merge write immediately, not just at the next edge.
    if (reset) begin
      stall          = 1'b0;
      dmWriteEnabled = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      result_valid_reg <= 1'b0;
      result_data_reg  <= 32'd0;
      misaligned_reg   <= 1'b0;
      merge_word_reg   <= 32'd0;
      merge_addr_reg   <= 32'd0;
      merge_pc_reg     <= 32'd0;
    end else begin
      state_reg        <= state_next;
      result_valid_reg <= in_idle & load_ok;
      misaligned_reg   <= in_idle & fault;
      if (in_idle & load_ok)
        result_data_reg <= load_value;
      if (in_idle & sub_store) begin
        merge_word_reg <= merged_word;
        merge_addr_reg <= reqAddress;
        merge_pc_reg   <= reqPc;
      end
    end
  end

  assign resultValid = result_valid_reg;
  assign resultData  = result_data_reg;
  assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-only data memory attached.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic [31:0] reqAddress = '0, reqData = '0, reqPc = '0;
  logic        stall, resultValid, misaligned, dmWriteEnabled;
  logic [31:0] resultData, dmProgramCounter, dmAddress, dmWriteInput, dmReadResult;

  logic [31:0] mem [0:2047];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign dmReadResult = mem[dmAddress[12:2]];
  always @(posedge clock) if (dmWriteEnabled) mem[dmAddress[12:2]] <= dmWriteInput;

  mem_access_unit #(.ADDR_MSB(12)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddress(reqAddress),
    .reqData(reqData), .reqPc(reqPc), .stall(stall), .resultValid(resultValid),
    .resultData(resultData), .misaligned(misaligned),
    .dmProgramCounter(dmProgramCounter), .dmAddress(dmAddress),
    .dmWriteEnabled(dmWriteEnabled), .dmWriteInput(dmWriteInput),
    .dmReadResult(dmReadResult)
  );

  task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    reqValid = v; reqWrite = w; reqSize = sz; reqUnsigned = u;
    reqAddress = a; reqData = d; reqPc = 32'h0000_4000 + a;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
    step();
    checks++;
    if (stall !== 1'b0 || dmWriteEnabled !== 1'b0) begin
      failures++;
      $display("FAIL reset_override: stall=%b we=%b required 0 0", stall, dmWriteEnabled);
    end
    step();
    checks++;
    if (resultValid !== 1'b0 || resultData !== 32'd0 || misaligned !== 1'b0 || mem[4] !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: rv=%b rd=%h mis=%b mem4=%h required 0 0 0 0",
               resultValid, resultData, misaligned, mem[4]);
    end
    $display("reset: rv=%b rd=%h mis=%b", resultValid, resultData, misaligned);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_store_load();
    drive(1, 1, 2'b10, 0, 32'h10, 32'h1234_5678);
    #1;
    checks++;
    if (dmWriteEnabled !== 1'b1 || stall !== 1'b0 || dmWriteInput !== 32'h1234_5678 ||
        dmAddress !== 32'h10 || dmProgramCounter !== 32'h4010) begin
      failures++;
      $display("FAIL sw_comb: we=%b stall=%b wi=%h addr=%h pc=%h required 1 0 12345678 10 4010",
               dmWriteEnabled, stall, dmWriteInput, dmAddress, dmProgramCounter);
    end
    step();
    $display("sw 0x10: mem4=%h", mem[4]);
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0 || dmWriteEnabled !== 1'b0) begin
      failures++;
      $display("FAIL lw_comb: stall=%b we=%b required 0 0", stall, dmWriteEnabled);
    end
    step();
    checks++;
    if (resultValid !== 1'b1 || resultData !== 32'h1234_5678) begin
      failures++;
      $display("FAIL lw_result: rv=%b rd=%h required 1 12345678", resultValid, resultData);
    end
    $display("lw 0x10: rv=%b rd=%h", resultValid, resultData);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    step();
    checks++;
    if (resultValid !== 1'b0 || resultData !== 32'h1234_5678) begin
      failures++;
      $display("FAIL idle_hold: rv=%b rd=%h required 0 12345678", resultValid, resultData);
    end
  endtask

  task automatic test_sub_store();
    drive(1, 1, 2'b00, 0, 32'h11, 32'hFFFF_FFAB);
    #1;
    checks++;
    if (stall !== 1'b1 || dmWriteEnabled !== 1'b0) begin
      failures++;
      $display("FAIL sb_read_phase: stall=%b we=%b required 1 0", stall, dmWriteEnabled);
    end
    step();
    checks++;
    if (stall !== 1'b0 || dmWriteEnabled !== 1'b1 || dmWriteInput !== 32'h1234_AB78 ||
        dmAddress !== 32'h11 || dmProgramCounter !== 32'h4011) begin
      failures++;
      $display("FAIL sb_merge: stall=%b we=%b wi=%h addr=%h pc=%h required 0 1 1234ab78 11 4011",
               stall, dmWriteEnabled, dmWriteInput, dmAddress, dmProgramCounter);
    end
    step();
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    #1;
    checks++;
    if (mem[4] !== 32'h1234_AB78 || stall !== 1'b0 || dmWriteEnabled !== 1'b0) begin
      failures++;
      $display("FAIL sb_commit: mem4=%h stall=%b we=%b required 1234ab78 0 0",
               mem[4], stall, dmWriteEnabled);
    end
    $display("sb 0xAB->0x11: mem4=%h", mem[4]);
  endtask

  task automatic test_loads();
    logic [31:0] addr_t [5] = '{32'h11, 32'h11, 32'h10, 32'h10, 32'h12};
    logic [1:0]  size_t [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic        uns_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_t  [5] = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'hFFFF_AB78,
                                32'h0000_AB78, 32'h0000_1234};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, size_t[i], uns_t[i], addr_t[i], 32'h0);
      step();
      checks++;
      if (resultValid !== 1'b1 || resultData !== exp_t[i]) begin
        failures++;
        $display("FAIL load_%0d: rv=%b rd=%h required 1 %h", i, resultValid, resultData, exp_t[i]);
      end
      $display("load addr=%h size=%0d uns=%b: rd=%h", addr_t[i], size_t[i], uns_t[i], resultData);
    end
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
  endtask

  task automatic test_misaligned();
    logic [31:0] addr_t [2] = '{32'h13, 32'h12};
    logic [1:0]  size_t [2] = '{2'b01, 2'b10};
    logic        wr_t   [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(1, wr_t[i], size_t[i], 0, addr_t[i], 32'hCAFE_F00D);
      #1;
      checks++;
      if (stall !== 1'b0 || dmWriteEnabled !== 1'b0) begin
        failures++;
        $display("FAIL misalign_comb_%0d: stall=%b we=%b required 0 0", i, stall, dmWriteEnabled);
      end
      step();
      checks++;
      if (misaligned !== 1'b1 || resultValid !== 1'b0) begin
        failures++;
        $display("FAIL misalign_pulse_%0d: mis=%b rv=%b required 1 0", i, misaligned, resultValid);
      end
      $display("misaligned addr=%h size=%0d: mis=%b", addr_t[i], size_t[i], misaligned);
    end
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    step();
    checks++;
    if (misaligned !== 1'b0 || mem[4] !== 32'h1234_AB78) begin
      failures++;
      $display("FAIL misalign_end: mis=%b mem4=%h required 0 1234ab78", misaligned, mem[4]);
    end
  endtask

  task automatic test_reset_in_merge();
    drive(1, 1, 2'b00, 0, 32'h10, 32'h0000_00CD);
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (dmWriteEnabled !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL merge_reset_comb: we=%b stall=%b required 0 0", dmWriteEnabled, stall);
    end
    step();
    reset = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h14, 32'h0);
    #1;
    checks++;
    if (mem[4] !== 32'h1234_AB78 || dmAddress !== 32'h14 || stall !== 1'b0 ||
        resultValid !== 1'b0 || resultData !== 32'd0 || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL merge_reset_after: mem4=%h addr=%h stall=%b rv=%b rd=%h mis=%b required 1234ab78 14 0 0 0 0",
               mem[4], dmAddress, stall, resultValid, resultData, misaligned);
    end
    $display("reset in MERGE: mem4=%h", mem[4]);
    step();
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 2'b00, 0, 32'h12, 32'h0000_00EF);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall1: stall=%b required 1", stall);
    end
    step();
    checks++;
    if (stall !== 1'b0 || dmWriteEnabled !== 1'b1 || dmWriteInput !== 32'h12EF_AB78) begin
      failures++;
      $display("FAIL b2b_merge1: stall=%b we=%b wi=%h required 0 1 12efab78",
               stall, dmWriteEnabled, dmWriteInput);
    end
    step();
    drive(1, 1, 2'b00, 0, 32'h13, 32'h0000_0001);
    #1;
    checks++;
    if (stall !== 1'b1 || dmWriteEnabled !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stall2: stall=%b we=%b required 1 0", stall, dmWriteEnabled);
    end
    step();
    checks++;
    if (stall !== 1'b0 || dmWriteInput !== 32'h01EF_AB78) begin
      failures++;
      $display("FAIL b2b_merge2: stall=%b wi=%h required 0 01efab78", stall, dmWriteInput);
    end
    step();
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    #1;
    checks++;
    if (mem[4] !== 32'h01EF_AB78 || stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final: mem4=%h stall=%b required 01efab78 0", mem[4], stall);
    end
    $display("back-to-back sb: mem4=%h", mem[4]);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    test_reset();
    test_word_store_load();
    test_sub_store();
    test_loads();
    test_misaligned();
    test_reset_in_merge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
